// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-period math.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, flow-control and received-byte signals of the UART receiver.
interface uart_rx_if;
    logic       rx;
    logic       cts;
    logic       cts_sync;
    logic       rts;
    logic [7:0] data_read;
    logic       valid_byte;
    logic       error;

    modport slave (
        input  rx,
        input  cts,
        output cts_sync,
        output rts,
        output data_read,
        output valid_byte,
        output error
    );

    modport master (
        output rx,
        output cts,
        input  cts_sync,
        input  rts,
        input  data_read,
        input  valid_byte,
        input  error
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, sticky framing error and break hold-off.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD        = 115200
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned TW           = $clog2(CLKS_PER_BIT) + 1;

    typedef logic [TW-1:0] timer_t;

    localparam timer_t BIT_LAST  = timer_t'(CLKS_PER_BIT - 1);
    localparam timer_t HALF_LAST = timer_t'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta, rx_s;
    logic        cts_meta, cts_s;

    uart_state_t state, state_n;
    timer_t      timer, timer_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_q, data_n;
    logic        valid_q, valid_n;
    logic        error_q, error_n;
    logic        rts_q, rts_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            cts_meta <= 1'b1;
            cts_s    <= 1'b1;
            state    <= IDLE;
            timer    <= '0;
            idx      <= '0;
            shift    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            rts_q    <= 1'b1;
        end else begin
            rx_meta  <= bus.rx;
            rx_s     <= rx_meta;
            cts_meta <= bus.cts;
            cts_s    <= cts_meta;
            state    <= state_n;
            timer    <= timer_n;
            idx      <= idx_n;
            shift    <= shift_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            error_q  <= error_n;
            rts_q    <= rts_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_q;
        valid_n = 1'b0;
        error_n = error_q;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Re-check at the centre of the start bit to reject short glitches.
                if (timer == HALF_LAST) begin
                    timer_n = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_n      = '0;
                    shift_n[idx] = rx_s;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        error_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        error_n = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            BREAK: begin
                timer_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        rts_n = (state_n == BREAK);
    end

    assign bus.data_read  = data_q;
    assign bus.valid_byte = valid_q;
    assign bus.error      = error_q;
    assign bus.rts        = rts_q;
    assign bus.cts_sync   = cts_s;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 12 MHz / 115200 baud (104 clocks per bit).
module tb_uart_rx;

    localparam int unsigned CPB     = 104;
    localparam int unsigned LATENCY = 991;

    logic clk;
    logic reset;

    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQ_HZ(12000000),
        .BAUD       (115200)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned cyc       = 0;
    int unsigned pulses    = 0;
    int unsigned last_cyc  = 0;
    int unsigned start_cyc = 0;
    int unsigned rts_hi    = 0;
    int unsigned doubles   = 0;
    logic [7:0]  last_data = '0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid_byte) begin
            pulses    = pulses + 1;
            last_cyc  = cyc;
            last_data = bus.data_read;
            if (prev_valid) doubles = doubles + 1;
        end
        prev_valid = bus.valid_byte;
        if (bus.rts) rts_hi = rts_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge exactly one frame later.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rx    = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    int unsigned p0;
    logic [7:0]  first_data;

    initial begin
        bus.rx  = 1'b1;
        bus.cts = 1'b1;
        reset   = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_data",  bus.data_read,  32'h00);
        check("reset_valid", bus.valid_byte, 32'h0);
        check("reset_error", bus.error,      32'h0);
        check("reset_rts",   bus.rts,        32'h1);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_rts", bus.rts, 32'h0);

        // Single byte 0xA5
        rts_hi = 0;
        p0 = pulses;
        send_frame(8'hA5, 1'b1);
        repeat (50) @(negedge clk);
        check("a5_pulses",  pulses - p0,      32'd1);
        check("a5_data",    bus.data_read,    32'hA5);
        check("a5_error",   bus.error,        32'h0);
        check("a5_rts",     rts_hi,           32'd0);
        check("a5_latency", last_cyc - start_cyc, LATENCY);

        // Back-to-back 0x00 then 0xFF
        p0 = pulses;
        send_frame(8'h00, 1'b1);
        first_data = bus.data_read;
        send_frame(8'hFF, 1'b1);
        repeat (50) @(negedge clk);
        check("b2b_first", first_data,     32'h00);
        check("b2b_pulses", pulses - p0,   32'd2);
        check("b2b_second", bus.data_read, 32'hFF);

        // 30-clock glitch
        p0 = pulses;
        bus.rx = 1'b0;
        repeat (30) @(negedge clk);
        bus.rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_pulses", pulses - p0,   32'd0);
        check("glitch_data",   bus.data_read, 32'hFF);
        check("glitch_rts",    bus.rts,       32'h0);

        // Framing error then held-low line
        p0 = pulses;
        send_frame(8'h3C, 1'b0);
        repeat (2000 - CPB) @(negedge clk);
        check("break_error",  bus.error,     32'h1);
        check("break_rts",    bus.rts,       32'h1);
        check("break_pulses", pulses - p0,   32'd0);
        check("break_data",   bus.data_read, 32'hFF);
        bus.rx = 1'b1;
        repeat (300) @(negedge clk);
        check("break_sticky", bus.error, 32'h1);
        check("break_rts_rel", bus.rts,  32'h0);
        send_frame(8'h81, 1'b1);
        repeat (50) @(negedge clk);
        check("recover_pulses", pulses - p0,   32'd1);
        check("recover_data",   bus.data_read, 32'h81);
        check("recover_error",  bus.error,     32'h0);
        check("recover_rts",    bus.rts,       32'h0);

        // Reset in the middle of data bit 4
        p0 = pulses;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_data",  bus.data_read,  32'h00);
        check("midrst_valid", bus.valid_byte, 32'h0);
        check("midrst_error", bus.error,      32'h0);
        check("midrst_rts",   bus.rts,        32'h1);
        repeat (10) @(negedge clk);
        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (1200) @(negedge clk);
        check("midrst_pulses", pulses - p0, 32'd0);
        p0 = pulses;
        send_frame(8'h55, 1'b1);
        repeat (50) @(negedge clk);
        check("after_rst_pulses", pulses - p0,   32'd1);
        check("after_rst_data",   bus.data_read, 32'h55);

        // CTS toggling during reception
        p0 = pulses;
        rts_hi = 0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (40) begin
                    repeat (23) @(negedge clk);
                    bus.cts = ~bus.cts;
                end
            end
        join
        repeat (50) @(negedge clk);
        check("cts_pulses",  pulses - p0,         32'd1);
        check("cts_data",    bus.data_read,       32'h5A);
        check("cts_latency", last_cyc - start_cyc, LATENCY);
        check("cts_rts",     rts_hi,              32'd0);
        bus.cts = 1'b0;
        repeat (3) @(negedge clk);
        check("cts_sync_lo", bus.cts_sync, 32'h0);
        bus.cts = 1'b1;
        repeat (3) @(negedge clk);
        check("cts_sync_hi", bus.cts_sync, 32'h1);

        check("single_cycle_pulses", doubles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division, 104 at defaults).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk).
REQ-005 rx  input  1  asynchronous serial data line, idle high, 8N1 framing, LSB first.
REQ-006 cts  input  1  CTS# from peer, active-low; synchronized, no effect on reception.
REQ-007 rts  output  1  RTS# to peer, active-low; 0 = receiver ready.
REQ-008 data_read  output  8  last correctly framed byte received.
REQ-009 valid_byte  output  1  one-cycle pulse when data_read is updated.
REQ-010 error  output  1  sticky framing-error flag.

Function
REQ-011 rx and cts each pass through a 2-flop synchronizer (rx reset value 1) before use; rx latency to FSM is 2 cycles.
REQ-012 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: synchronized rx == 0 -> START, bit-timer cleared.
REQ-014 START: after CLKS_PER_BIT/2 cycles, resample; 0 -> DATA with timer cleared, bit index 0; 1 -> IDLE (glitch rejected, no outputs change).
REQ-015 DATA: every CLKS_PER_BIT cycles sample rx into shift register bit[index], LSB first; after bit 7 -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample rx; 1 -> data_read <= shift register, valid_byte = 1 for exactly one cycle, error <= 0, -> IDLE.
REQ-017 STOP sample 0 -> error <= 1, data_read unchanged, no valid_byte pulse, -> BREAK.
REQ-018 BREAK: stay until synchronized rx == 1, then -> IDLE (a held-low line generates exactly one error event).
REQ-019 error remains 1 until the next correctly framed byte or reset.
REQ-020 rts = 0 in IDLE, START, DATA, STOP; rts = 1 in BREAK and during reset.
REQ-021 Bit timer width = clog2(CLKS_PER_BIT)+1 bits; counters never wrap mid-bit.
REQ-022 valid_byte is a registered output; data_read is stable from the valid_byte cycle until the next valid_byte.

Reset
REQ-023 While reset == 0: state IDLE, data_read = 8'h00, valid_byte = 0, error = 0, rts = 1, synchronizers = 1, counters = 0.
REQ-024 Reset asserted mid-frame aborts the frame with no valid_byte or error output; reception resumes from IDLE after release.

Structure
REQ-025 FSM state encoding and the CLKS_PER_BIT computation belong in a shared package uart_pkg, reusable by a future uart_tx.
REQ-026 Single module; no sub-modules required (synchronizer may be inline).

Verification
REQ-027 Send 0xA5 at 115200 baud (104 clk/bit) -> one valid_byte pulse, data_read = 0xA5, error = 0, rts = 0 throughout.
REQ-028 Back-to-back 0x00 then 0xFF with single stop bits -> two valid_byte pulses, data_read 0x00 then 0xFF.
REQ-029 rx low for 30 clocks then high -> no valid_byte, state returns to IDLE, data_read unchanged.
REQ-030 Frame 0x3C with stop bit 0, rx held low 2000 clocks, then valid 0x81 -> error = 1 and rts = 1 while low, no pulse for 0x3C; after 0x81 error = 0, rts = 0, data_read = 0x81.
REQ-031 Assert reset during data bit 4 of a frame -> outputs at reset values, no valid_byte; next full frame 0x55 received correctly.
REQ-032 Toggle cts during reception of 0x5A -> data_read = 0x5A, timing unaffected.
